// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state type, parity-mode encodings and default frame width.
// Used by the transmitter here and by the receiver's parity checker.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_parity_if.sv
// Request/status bundle between the register block (master) and the UART transmitter (slave).
// UART_TX_STOP2_EN adds the stop2 request field.
`timescale 1ns/1ps
interface uart_tx_parity_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              tx_start;
  logic [DATA_W-1:0] tx_data_in;
  logic              parity_en;
  logic              parity_odd;
`ifdef UART_TX_STOP2_EN
  logic              stop2;
`endif
  logic              tx;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    output tx_start, tx_data_in, parity_en, parity_odd,
`ifdef UART_TX_STOP2_EN
    output stop2,
`endif
    input  tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data_in, parity_en, parity_odd,
`ifdef UART_TX_STOP2_EN
    input  stop2,
`endif
    output tx, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
`timescale 1ns/1ps
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_bit_tick
);

  localparam int              CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap     = (r_cnt == LAST);
  assign o_bit_tick = i_en && w_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear || !i_en) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, DATA_W data bits LSB-first, optional parity bit, stop bit(s).
// Define UART_TX_STOP2_EN to add a per-frame second stop bit selected by stop2.
`timescale 1ns/1ps
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  uart_tx_parity_if.slave  bus
);

  localparam int             BCW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  function automatic logic frame_parity(input logic [DATA_W-1:0] d, input logic mode);
    return (^d) ^ (mode == PARITY_ODD);
  endfunction

  tx_state_t         r_state, w_state_nx;
  logic              r_tx, w_tx_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;
  logic [DATA_W-1:0] r_shift, w_shift_nx;
  logic [BCW-1:0]    r_bitcnt, w_bitcnt_nx;
  logic              r_par_en;
  logic              r_par_bit;
  logic              w_accept;
  logic              w_bit_tick;
  logic              w_timer_en;
`ifdef UART_TX_STOP2_EN
  logic              r_stop2;
  logic              r_stop_2nd, w_stop_2nd_nx;
`endif

  assign w_timer_en = (r_state != ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .i_clk      (PCLK),
    .i_rst_n    (PRESETn),
    .i_clear    (w_accept),
    .i_en       (w_timer_en),
    .o_bit_tick (w_bit_tick)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_tx_nx     = r_tx;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_shift_nx  = r_shift;
    w_bitcnt_nx = r_bitcnt;
    w_accept    = 1'b0;
`ifdef UART_TX_STOP2_EN
    w_stop_2nd_nx = r_stop_2nd;
`endif
    unique case (r_state)
      ST_IDLE: begin
        w_tx_nx   = 1'b1;
        w_busy_nx = 1'b0;
        if (bus.tx_start) begin
          w_accept    = 1'b1;
          w_state_nx  = ST_START;
          w_tx_nx     = 1'b0;
          w_busy_nx   = 1'b1;
          w_shift_nx  = bus.tx_data_in;
          w_bitcnt_nx = '0;
`ifdef UART_TX_STOP2_EN
          w_stop_2nd_nx = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (w_bit_tick) begin
          w_state_nx = ST_DATA;
          w_tx_nx    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_tick) begin
          if (r_bitcnt == LAST_BIT) begin
            if (r_par_en) begin
              w_state_nx = ST_PARITY;
              w_tx_nx    = r_par_bit;
            end else begin
              w_state_nx = ST_STOP;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_bitcnt_nx = r_bitcnt + BCW'(1);
            w_shift_nx  = r_shift >> 1;
            w_tx_nx     = w_shift_nx[0];
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_tick) begin
          w_state_nx = ST_STOP;
          w_tx_nx    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_tick) begin
`ifdef UART_TX_STOP2_EN
          // First stop-bit period of a two-stop frame: stay for one more bit.
          if (r_stop2 && !r_stop_2nd) w_stop_2nd_nx = 1'b1;
          else
`endif
          begin
            w_state_nx = ST_IDLE;
            w_tx_nx    = 1'b1;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
`ifdef UART_TX_STOP2_EN
            w_stop_2nd_nx = 1'b0;
`endif
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_tx_nx    = 1'b1;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state  <= ST_IDLE;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bitcnt <= '0;
`ifdef UART_TX_STOP2_EN
      r_stop_2nd <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_tx     <= w_tx_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_bitcnt <= w_bitcnt_nx;
`ifdef UART_TX_STOP2_EN
      r_stop_2nd <= w_stop_2nd_nx;
`endif
    end
  end

  // Frame payload and configuration: only meaningful while busy, so left out of reset.
  always_ff @(posedge PCLK) begin
    r_shift <= w_shift_nx;
    if (w_accept) begin
      r_par_en  <= bus.parity_en;
      r_par_bit <= frame_parity(bus.tx_data_in, bus.parity_odd);
`ifdef UART_TX_STOP2_EN
      r_stop2   <= bus.stop2;
`endif
    end
  end

  assign bus.tx      = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Testbench for uart_tx_parity: waveform-queue reference model plus directed literal frame checks.
// Honours UART_TX_STOP2_EN when the design is built with it.
`timescale 1ns/1ps
module tb_uart_tx_parity;

  localparam int DATA_W = 8;
  localparam int CPB    = 16;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  logic stop2_v = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  uart_tx_parity_if #(.DATA_W(DATA_W)) bus();

`ifdef UART_TX_STOP2_EN
  assign bus.stop2 = stop2_v;
`endif

  uart_tx_parity #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: each accepted request expands into the per-cycle {tx,busy,done} waveform.
  logic [2:0] q[$];
  logic [2:0] cur = 3'b100;

  task automatic build_frame(input logic [DATA_W-1:0] d, input logic pe, input logic po,
                             input logic s2);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) b.push_back(d[i]);
    if (pe) b.push_back((^d) ^ po);
    b.push_back(1'b1);
`ifdef UART_TX_STOP2_EN
    if (s2) b.push_back(1'b1);
`else
    if (s2 && 1'b0) b.push_back(1'b1);
`endif
    foreach (b[k]) repeat (CPB) q.push_back({b[k], 1'b1, 1'b0});
    q.push_back(3'b101);
  endtask

  always @(posedge PCLK) begin
    if (!PRESETn) begin
      q.delete();
      cur = 3'b100;
    end else begin
      if (q.size() == 0 && bus.tx_start)
        build_frame(bus.tx_data_in, bus.parity_en, bus.parity_odd, stop2_v);
      if (q.size() != 0) cur = q.pop_front();
      else cur = 3'b100;
    end
  end

  always @(negedge PCLK) begin
    if (chk_en) begin
      n_tests++;
      if ({bus.tx, bus.tx_busy, bus.tx_done} !== cur) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model_cmp @%0t actual tx/busy/done=%b required=%b", $time,
                   {bus.tx, bus.tx_busy, bus.tx_done}, cur);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.tx_busy && k < 600) begin
      @(negedge PCLK);
      k++;
    end
    chk("idle_timeout", int'(bus.tx_busy), 0);
  endtask

  // Sends one frame and checks each bit mid-period against a hand-computed sequence.
  task automatic frame_check(input logic [7:0] d, input logic pe, input logic po, input logic s2,
                             input logic [15:0] exp_seq, input int nbits, input int exp_len,
                             input string nm);
    int c = 0;
    bit seen = 1'b0;
    wait_idle();
    bus.tx_start   = 1'b1;
    bus.tx_data_in = d;
    bus.parity_en  = pe;
    bus.parity_odd = po;
    stop2_v        = s2;
    @(negedge PCLK);
    bus.tx_start   = 1'b0;
    bus.tx_data_in = ~d;
    bus.parity_en  = ~pe;
    bus.parity_odd = ~po;
    stop2_v        = ~s2;
    while (c < 1000 && !seen) begin
      if ((c % CPB) == CPB / 2 && (c / CPB) < nbits)
        chk({nm, "_bit"}, int'(bus.tx), int'(exp_seq[c / CPB]));
      if (bus.tx_done) begin
        seen = 1'b1;
        chk({nm, "_len"}, c, exp_len);
      end else begin
        @(negedge PCLK);
        c++;
      end
    end
    chk({nm, "_done_seen"}, int'(seen), 1);
    stop2_v = 1'b0;
  endtask

  initial begin
    int n_done;
    int n_busy;
    int k;
    bus.tx_start   = 1'b0;
    bus.tx_data_in = '0;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    PRESETn        = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_tx", int'(bus.tx), 1);
    chk("rst_busy", int'(bus.tx_busy), 0);
    chk("rst_done", int'(bus.tx_done), 0);
    chk_en  = 1'b1;
    PRESETn = 1'b1;
    @(negedge PCLK);

    frame_check(8'hF0, 1'b1, 1'b0, 1'b0, 16'h05E0, 11, 176, "f0_even");
    frame_check(8'hC0, 1'b1, 1'b1, 1'b0, 16'h0780, 11, 176, "c0_odd");
    frame_check(8'h07, 1'b1, 1'b0, 1'b0, 16'h060E, 11, 176, "07_even");
    frame_check(8'hA5, 1'b0, 1'b0, 1'b0, 16'h034A, 10, 160, "a5_nopar");
`ifdef UART_TX_STOP2_EN
    frame_check(8'hA5, 1'b0, 1'b0, 1'b1, 16'h074A, 11, 176, "a5_stop2");
`endif

    // Request while busy is dropped.
    wait_idle();
    bus.tx_start = 1'b1; bus.tx_data_in = 8'h5A; bus.parity_en = 1'b1; bus.parity_odd = 1'b0;
    @(negedge PCLK);
    bus.tx_start = 1'b0;
    repeat (50) @(negedge PCLK);
    bus.tx_start = 1'b1; bus.tx_data_in = 8'h3C;
    @(negedge PCLK);
    bus.tx_start = 1'b0;
    n_done = 0;
    repeat (400) begin
      @(negedge PCLK);
      if (bus.tx_done) n_done++;
    end
    chk("ignore_done_count", n_done, 1);

    // Back-to-back: request held through the done cycle starts the next frame right after.
    wait_idle();
    bus.tx_start = 1'b1; bus.tx_data_in = 8'h55; bus.parity_en = 1'b0;
    @(negedge PCLK);
    k = 0;
    while (!bus.tx_done && k < 400) begin
      @(negedge PCLK);
      k++;
    end
    chk("b2b_done_seen", int'(bus.tx_done), 1);
    chk("b2b_done_tx", int'(bus.tx), 1);
    bus.tx_data_in = 8'h81;
    @(negedge PCLK);
    chk("b2b_start_tx", int'(bus.tx), 0);
    chk("b2b_start_busy", int'(bus.tx_busy), 1);
    bus.tx_start = 1'b0;

    // Reset in the middle of a frame.
    wait_idle();
    bus.tx_start = 1'b1; bus.tx_data_in = 8'h00; bus.parity_en = 1'b1;
    @(negedge PCLK);
    bus.tx_start = 1'b0;
    repeat (40) @(negedge PCLK);
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_tx", int'(bus.tx), 1);
    chk("rst_mid_busy", int'(bus.tx_busy), 0);
    chk("rst_mid_done", int'(bus.tx_done), 0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    n_done = 0;
    n_busy = 0;
    repeat (250) begin
      @(negedge PCLK);
      if (bus.tx_done) n_done++;
      if (bus.tx_busy) n_busy++;
    end
    chk("rst_no_done", n_done, 0);
    chk("rst_no_busy", n_busy, 0);

    // Random traffic against the model.
    for (int i = 0; i < 8000; i++) begin
      bus.tx_start   = ($urandom_range(0, 7) == 0);
      bus.tx_data_in = DATA_W'($urandom);
      bus.parity_en  = 1'($urandom);
      bus.parity_odd = 1'($urandom);
      stop2_v        = 1'($urandom);
      PRESETn        = ($urandom_range(0, 2999) != 0);
      @(negedge PCLK);
    end
    bus.tx_start = 1'b0;
    PRESETn      = 1'b1;
    wait_idle();
    repeat (4) @(negedge PCLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
